// File: rtl/rat_pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: decode classes,
// controller states and default post-event bubble lengths.
package rat_pipe_pkg;

  localparam int INSTR_W   = 4;
  localparam int MAX_FLUSH = 15;

  localparam int DEF_FLUSH_BR   = 2;
  localparam int DEF_FLUSH_CALL = 2;
  localparam int DEF_FLUSH_RET  = 3;
  localparam int DEF_FLUSH_INT  = 2;
  localparam int DEF_FLUSH_RST  = 2;

  localparam logic [INSTR_W-1:0] CLS_BR_LO  = 4'd1;
  localparam logic [INSTR_W-1:0] CLS_BR_HI  = 4'd5;
  localparam logic [INSTR_W-1:0] CLS_CALL   = 4'd6;
  localparam logic [INSTR_W-1:0] CLS_RET_LO = 4'd7;
  localparam logic [INSTR_W-1:0] CLS_RET_HI = 4'd9;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_RST_FLUSH
  } state_t;

  typedef enum logic [1:0] {
    ICLS_NONE,
    ICLS_BRANCH,
    ICLS_CALL,
    ICLS_RETURN
  } instr_class_t;

  function automatic instr_class_t classify(input logic [INSTR_W-1:0] t);
    if (t >= CLS_BR_LO && t <= CLS_BR_HI)        return ICLS_BRANCH;
    else if (t == CLS_CALL)                       return ICLS_CALL;
    else if (t >= CLS_RET_LO && t <= CLS_RET_HI)  return ICLS_RETURN;
    else                                          return ICLS_NONE;
  endfunction

  function automatic bit flush_ok(input int n);
    return (n >= 0) && (n <= MAX_FLUSH);
  endfunction

endpackage

// File: rtl/hazard_control_if.sv
// Decode-side inputs and PC/fetch control outputs of the hazard controller.
interface hazard_control_if
  import rat_pipe_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 2
);
  logic [REG_AW-1:0]            reg_a;
  logic [REG_AW-1:0]            reg_b;
  logic                         a_read;
  logic                         b_read;
  logic [NUM_STAGES*REG_AW-1:0] reg_dst;
  logic [NUM_STAGES-1:0]        reg_dst_en;
  logic [INSTR_W-1:0]           instr_type;
  logic                         branch_taken;
  logic                         interrupt;
  logic                         mem_busy;

  logic fetch_stall;
  logic imem_addr_mux;
  logic dec_nop;
  logic pc_inc;
  logic pc_load;
  logic pc_reset;
  logic int_ack;
  logic flush_active;

  modport master (
    output reg_a, reg_b, a_read, b_read, reg_dst, reg_dst_en,
           instr_type, branch_taken, interrupt, mem_busy,
    input  fetch_stall, imem_addr_mux, dec_nop, pc_inc, pc_load,
           pc_reset, int_ack, flush_active
  );

  modport slave (
    input  reg_a, reg_b, a_read, b_read, reg_dst, reg_dst_en,
           instr_type, branch_taken, interrupt, mem_busy,
    output fetch_stall, imem_addr_mux, dec_nop, pc_inc, pc_load,
           pc_reset, int_ack, flush_active
  );
endinterface

// File: rtl/hazard_detect.sv
// Read-after-write detector: flags a decode source that matches the
// destination of any downstream stage that will write the register file.
module hazard_detect #(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 2
) (
  input  logic [REG_AW-1:0]            reg_a,
  input  logic [REG_AW-1:0]            reg_b,
  input  logic                         a_read,
  input  logic                         b_read,
  input  logic [NUM_STAGES*REG_AW-1:0] reg_dst,
  input  logic [NUM_STAGES-1:0]        reg_dst_en,
  output logic                         raw
);
  logic [NUM_STAGES-1:0] hit;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    logic [REG_AW-1:0] dst;
    assign dst     = reg_dst[gi*REG_AW +: REG_AW];
    assign hit[gi] = reg_dst_en[gi] &
                     ((a_read & (reg_a == dst)) | (b_read & (reg_b == dst)));
  end

  assign raw = |hit;
endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: sequences control-flow flush bubbles, RAW
// stalls, interrupt entry and post-reset bubbles for the fetch/decode stages.
module hazard_control
  import rat_pipe_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 2,
  parameter int FLUSH_BR   = DEF_FLUSH_BR,
  parameter int FLUSH_CALL = DEF_FLUSH_CALL,
  parameter int FLUSH_RET  = DEF_FLUSH_RET,
  parameter int FLUSH_INT  = DEF_FLUSH_INT,
  parameter int FLUSH_RST  = DEF_FLUSH_RST
) (
  input logic             clk,
  input logic             reset_n,
  hazard_control_if.slave bus
);

  if (!(flush_ok(FLUSH_BR) && flush_ok(FLUSH_CALL) && flush_ok(FLUSH_RET) &&
        flush_ok(FLUSH_INT) && flush_ok(FLUSH_RST))) begin : g_bad_flush
    $error("hazard_control: flush lengths must lie in 0..15");
  end

  state_t       state_reg, state_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic         int_pending_reg, int_pending_next;

  logic         raw;
  instr_class_t cls;
  logic         run_idle;
  logic         take_int;
  logic         ev_ret, ev_call, ev_br;
  logic [3:0]   ev_len;
  logic         dec_nop, pc_load, flush_active, raw_stall;
  logic         fetch_stall, pc_reset;

  hazard_detect #(
    .REG_AW     (REG_AW),
    .NUM_STAGES (NUM_STAGES)
  ) u_detect (
    .reg_a      (bus.reg_a),
    .reg_b      (bus.reg_b),
    .a_read     (bus.a_read),
    .b_read     (bus.b_read),
    .reg_dst    (bus.reg_dst),
    .reg_dst_en (bus.reg_dst_en),
    .raw        (raw)
  );

  // Only one event is accepted per cycle; the classes are mutually exclusive
  // so masking with take_int is enough to realise the priority order.
  assign cls      = classify(bus.instr_type);
  assign run_idle = (state_reg == ST_RUN) & ~bus.mem_busy;
  assign take_int = (bus.interrupt | int_pending_reg) & run_idle;
  assign ev_ret   = run_idle & ~take_int & (cls == ICLS_RETURN);
  assign ev_call  = run_idle & ~take_int & (cls == ICLS_CALL);
  assign ev_br    = run_idle & ~take_int & (cls == ICLS_BRANCH) & bus.branch_taken;
  assign ev_len   = take_int ? 4'(FLUSH_INT)  :
                    ev_ret   ? 4'(FLUSH_RET)  :
                    ev_call  ? 4'(FLUSH_CALL) : 4'(FLUSH_BR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_RST_FLUSH;
      cnt_reg         <= 4'(FLUSH_RST);
      int_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      int_pending_reg <= int_pending_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    int_pending_next = int_pending_reg;
    dec_nop          = 1'b0;
    pc_load          = 1'b0;
    flush_active     = 1'b0;
    raw_stall        = 1'b0;

    case (state_reg)
      ST_RUN: begin
        if (bus.mem_busy) begin
          dec_nop = 1'b1;
        end else if (take_int | ev_ret | ev_call | ev_br) begin
          dec_nop = 1'b1;
          pc_load = ~ev_call;
          if (ev_len != 4'd0) begin
            state_next = ST_FLUSH;
            cnt_next   = ev_len;
          end
        end else if (raw) begin
          dec_nop   = 1'b1;
          raw_stall = 1'b1;
        end
      end
      ST_FLUSH, ST_RST_FLUSH: begin
        dec_nop      = 1'b1;
        flush_active = 1'b1;
        // cnt_reg <= 1 also covers a zero-length post-reset flush
        if (!bus.mem_busy) begin
          if (cnt_reg <= 4'd1) begin
            state_next = ST_RUN;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt_reg - 4'd1;
          end
        end
      end
      default: begin
        state_next = ST_RST_FLUSH;
        cnt_next   = 4'(FLUSH_RST);
        dec_nop    = 1'b1;
      end
    endcase

    if (take_int)
      int_pending_next = 1'b0;
    else if (bus.interrupt)
      int_pending_next = 1'b1;
  end

  assign pc_reset          = ~reset_n;
  assign fetch_stall       = raw_stall | bus.mem_busy;
  assign bus.fetch_stall   = fetch_stall;
  assign bus.imem_addr_mux = fetch_stall;
  assign bus.dec_nop       = dec_nop;
  assign bus.pc_load       = pc_load;
  assign bus.pc_reset      = pc_reset;
  assign bus.pc_inc        = ~pc_reset & ~pc_load & ~fetch_stall;
  assign bus.int_ack       = take_int;
  assign bus.flush_active  = flush_active;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control with a bubble-count behavioural model
// checked every cycle, plus literal checks on the hand-worked scenarios.
module tb_hazard_control;
  localparam int AW     = 5;
  localparam int NS     = 2;
  localparam int F_BR   = 2;
  localparam int F_CALL = 2;
  localparam int F_RET  = 3;
  localparam int F_INT  = 2;
  localparam int F_RST  = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  hazard_control_if #(.REG_AW(AW), .NUM_STAGES(NS)) bus ();

  hazard_control #(
    .REG_AW     (AW),
    .NUM_STAGES (NS),
    .FLUSH_BR   (F_BR),
    .FLUSH_CALL (F_CALL),
    .FLUSH_RET  (F_RET),
    .FLUSH_INT  (F_INT),
    .FLUSH_RST  (F_RST)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  bit check_en = 1'b0;

  // Model state: bubble cycles still owed, and a latched interrupt request.
  int bub  = F_RST;
  bit pend = 1'b0;

  function automatic bit model_raw();
    bit r = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int d;
      d = int'((bus.reg_dst >> (i * AW)) & ((1 << AW) - 1));
      if (bus.reg_dst_en[i] &&
          ((bus.a_read && int'(bus.reg_a) == d) || (bus.b_read && int'(bus.reg_b) == d)))
        r = 1'b1;
    end
    return r;
  endfunction

  function automatic bit is_ret();
    return bus.instr_type >= 4'd7 && bus.instr_type <= 4'd9;
  endfunction

  function automatic bit is_call();
    return bus.instr_type == 4'd6;
  endfunction

  function automatic bit is_br_taken();
    return bus.branch_taken && bus.instr_type >= 4'd1 && bus.instr_type <= 4'd5;
  endfunction

  // {fetch_stall, imem_addr_mux, dec_nop, pc_inc, pc_load, pc_reset, int_ack, flush_active}
  function automatic logic [7:0] model_out();
    bit fs = 0, nop = 0, inc = 0, ld = 0, rst = 0, ack = 0, fa = 0;
    if (!reset_n) begin
      rst = 1; nop = 1; fa = 1; fs = bus.mem_busy;
    end else if (bub > 0) begin
      nop = 1; fa = 1; fs = bus.mem_busy; inc = !bus.mem_busy;
    end else if (bus.mem_busy) begin
      nop = 1; fs = 1;
    end else if (bus.interrupt || pend) begin
      ack = 1; ld = 1; nop = 1;
    end else if (is_ret() || is_br_taken()) begin
      ld = 1; nop = 1;
    end else if (is_call()) begin
      nop = 1; inc = 1;
    end else if (model_raw()) begin
      nop = 1; fs = 1;
    end else begin
      inc = 1;
    end
    return {fs, fs, nop, inc, ld, rst, ack, fa};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bub  <= F_RST;
      pend <= 1'b0;
    end else if (bub > 0) begin
      if (!bus.mem_busy) bub <= bub - 1;
      if (bus.interrupt) pend <= 1'b1;
    end else if (bus.mem_busy) begin
      if (bus.interrupt) pend <= 1'b1;
    end else if (bus.interrupt || pend) begin
      pend <= 1'b0;
      bub  <= F_INT;
    end else if (is_ret()) begin
      bub <= F_RET;
    end else if (is_call()) begin
      bub <= F_CALL;
    end else if (is_br_taken()) begin
      bub <= F_BR;
    end
  end

  always @(negedge clk) begin
    logic [7:0] got, want;
    cyc++;
    if (check_en) begin
      want = model_out();
      got  = {bus.fetch_stall, bus.imem_addr_mux, bus.dec_nop, bus.pc_inc,
              bus.pc_load, bus.pc_reset, bus.int_ack, bus.flush_active};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL cycle %0d outputs{stall,mux,nop,inc,load,rst,ack,flush} got %b want %b",
                 cyc, got, want);
      end
    end
  end

  task automatic lit(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.reg_a        = '0;
    bus.reg_b        = '0;
    bus.a_read       = 1'b0;
    bus.b_read       = 1'b0;
    bus.reg_dst      = '0;
    bus.reg_dst_en   = '0;
    bus.instr_type   = 4'd0;
    bus.branch_taken = 1'b0;
    bus.interrupt    = 1'b0;
    bus.mem_busy     = 1'b0;
  endtask

  typedef struct {
    logic [3:0] it;
    bit         bt;
    bit         irq;
    bit         busy;
    logic [4:0] ra;
    logic [1:0] en;
  } vec_t;

  vec_t tbl [12];

  initial begin
    idle();
    #1 reset_n = 1'b0;
    #1 check_en = 1'b1;

    // reset held with memory busy and an interrupt request
    bus.mem_busy  = 1'b1;
    bus.interrupt = 1'b1;
    mid();
    lit("rst_pc_reset", bus.pc_reset, 1'b1);
    lit("rst_pc_inc", bus.pc_inc, 1'b0);
    lit("rst_fetch_stall", bus.fetch_stall, 1'b1);
    lit("rst_dec_nop", bus.dec_nop, 1'b1);
    lit("rst_flush_active", bus.flush_active, 1'b1);
    lit("rst_int_ack", bus.int_ack, 1'b0);
    next();
    idle();
    next();

    // release: two post-reset bubbles, then RUN
    reset_n = 1'b1;
    mid();
    lit("rel1_dec_nop", bus.dec_nop, 1'b1);
    lit("rel1_pc_inc", bus.pc_inc, 1'b1);
    next();
    mid();
    lit("rel2_dec_nop", bus.dec_nop, 1'b1);
    next();
    mid();
    lit("rel3_dec_nop", bus.dec_nop, 1'b0);
    lit("rel3_int_ack", bus.int_ack, 1'b0);
    next();

    // RAW on reg_a against stage 1, held two cycles
    bus.reg_a = 5'd3; bus.a_read = 1'b1;
    bus.reg_dst = 10'(3 << AW); bus.reg_dst_en = 2'b10;
    mid();
    lit("raw1_fetch_stall", bus.fetch_stall, 1'b1);
    lit("raw1_pc_inc", bus.pc_inc, 1'b0);
    lit("raw1_dec_nop", bus.dec_nop, 1'b1);
    next();
    mid();
    lit("raw2_fetch_stall", bus.fetch_stall, 1'b1);
    next();
    bus.reg_dst_en = 2'b00;
    mid();
    lit("raw3_fetch_stall", bus.fetch_stall, 1'b0);
    lit("raw3_dec_nop", bus.dec_nop, 1'b0);
    next();

    // reg_b matches stage 0 but is only a hazard when b_read is set
    idle();
    bus.reg_b = 5'd7; bus.reg_dst = 10'd7; bus.reg_dst_en = 2'b01;
    mid();
    lit("rawb_unread_dec_nop", bus.dec_nop, 1'b0);
    next();
    bus.b_read = 1'b1;
    mid();
    lit("rawb_read_stall", bus.fetch_stall, 1'b1);
    next();
    idle();

    // taken branch: one load cycle, two flush bubbles
    bus.instr_type = 4'd2; bus.branch_taken = 1'b1;
    mid();
    lit("br_pc_load", bus.pc_load, 1'b1);
    lit("br_flush_active", bus.flush_active, 1'b0);
    next();
    idle();
    mid();
    lit("brf1_flush_active", bus.flush_active, 1'b1);
    lit("brf1_pc_inc", bus.pc_inc, 1'b1);
    next();
    mid();
    lit("brf2_dec_nop", bus.dec_nop, 1'b1);
    next();
    mid();
    lit("brf3_dec_nop", bus.dec_nop, 1'b0);
    next();

    // branch_taken on a non-branch class is not an event
    bus.instr_type = 4'd12; bus.branch_taken = 1'b1;
    mid();
    lit("nonbr_pc_load", bus.pc_load, 1'b0);
    next();
    idle();

    // interrupt wins over a simultaneous return
    bus.interrupt = 1'b1; bus.instr_type = 4'd7;
    mid();
    lit("irq_int_ack", bus.int_ack, 1'b1);
    lit("irq_pc_load", bus.pc_load, 1'b1);
    next();
    idle();
    next();
    next();
    mid();
    lit("irq_after2_dec_nop", bus.dec_nop, 1'b0);
    next();

    // plain return: three bubbles
    bus.instr_type = 4'd8;
    next();
    idle();
    repeat (4) next();

    // call, with an interrupt pulse in the second flush cycle
    bus.instr_type = 4'd6;
    mid();
    lit("call_pc_load", bus.pc_load, 1'b0);
    lit("call_pc_inc", bus.pc_inc, 1'b1);
    next();
    idle();
    next();
    bus.interrupt = 1'b1;
    mid();
    lit("callf2_int_ack", bus.int_ack, 1'b0);
    next();
    bus.interrupt = 1'b0;
    mid();
    lit("call_run_int_ack", bus.int_ack, 1'b1);
    next();
    repeat (2) next();

    // memory busy freezes a flush with two bubbles left
    bus.instr_type = 4'd3; bus.branch_taken = 1'b1;
    next();
    idle();
    bus.mem_busy = 1'b1;
    mid();
    lit("busy_fetch_stall", bus.fetch_stall, 1'b1);
    lit("busy_pc_inc", bus.pc_inc, 1'b0);
    next();
    next();
    next();
    bus.mem_busy = 1'b0;
    next();
    mid();
    lit("busy_rel2_dec_nop", bus.dec_nop, 1'b1);
    next();
    mid();
    lit("busy_rel3_dec_nop", bus.dec_nop, 1'b0);
    next();

    // busy RUN defers both an interrupt and a return
    bus.mem_busy = 1'b1; bus.interrupt = 1'b1; bus.instr_type = 4'd7;
    mid();
    lit("busyrun_int_ack", bus.int_ack, 1'b0);
    lit("busyrun_pc_load", bus.pc_load, 1'b0);
    next();
    idle();
    mid();
    lit("pending_int_ack", bus.int_ack, 1'b1);
    next();
    repeat (3) next();

    // reset mid-flush with an interrupt pending: nothing survives
    bus.instr_type = 4'd9;
    next();
    idle();
    bus.interrupt = 1'b1;
    next();
    bus.interrupt = 1'b0;
    reset_n = 1'b0;
    next();
    reset_n = 1'b1;
    next();
    next();
    mid();
    lit("postrst_no_int_ack", bus.int_ack, 1'b0);
    next();

    // interrupt raised during the post-reset flush is serviced after it
    reset_n = 1'b0;
    next();
    reset_n = 1'b1;
    bus.interrupt = 1'b1;
    next();
    bus.interrupt = 1'b0;
    next();
    mid();
    lit("rstflush_int_ack", bus.int_ack, 1'b1);
    next();
    repeat (2) next();

    // mixed table: dst stage1=9, stage0=4
    tbl[0]  = '{4'd0, 1'b0, 1'b0, 1'b0, 5'd4, 2'b01};
    tbl[1]  = '{4'd0, 1'b0, 1'b0, 1'b0, 5'd9, 2'b01};
    tbl[2]  = '{4'd0, 1'b0, 1'b0, 1'b0, 5'd9, 2'b10};
    tbl[3]  = '{4'd4, 1'b1, 1'b0, 1'b0, 5'd4, 2'b01};
    tbl[4]  = '{4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00};
    tbl[5]  = '{4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00};
    tbl[6]  = '{4'd5, 1'b0, 1'b0, 1'b0, 5'd9, 2'b11};
    tbl[7]  = '{4'd1, 1'b1, 1'b0, 1'b1, 5'd0, 2'b00};
    tbl[8]  = '{4'd15, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00};
    tbl[9]  = '{4'd6, 1'b0, 1'b0, 1'b0, 5'd4, 2'b01};
    tbl[10] = '{4'd0, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00};
    tbl[11] = '{4'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00};
    bus.reg_dst = {5'd9, 5'd4};
    bus.a_read  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.instr_type   = tbl[i].it;
      bus.branch_taken = tbl[i].bt;
      bus.interrupt    = tbl[i].irq;
      bus.mem_busy     = tbl[i].busy;
      bus.reg_a        = tbl[i].ra;
      bus.reg_dst_en   = tbl[i].en;
      next();
    end
    idle();
    repeat (5) next();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
